// File: rtl/delay_sum_beamformer_pkg.sv
// beamformer_pkg
//   Shared definitions for the delay-and-sum beamformer slice:
//   - default parameter values (NUM_CH_DEF, SAMPLE_W_DEF, DEPTH_DEF)
//   - FSM state encoding (IDLE, ACCUM)
//   - calc_out_w(): output width that holds the sum of num_ch samples exactly
package beamformer_pkg;

    localparam int NUM_CH_DEF   = 4;
    localparam int SAMPLE_W_DEF = 16;
    localparam int DEPTH_DEF    = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // One extra bit per doubling of the channel count keeps the sum exact.
    function automatic int calc_out_w(input int sample_w, input int num_ch);
        return sample_w + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/delay_sum_beamformer_if.sv
// delay_sum_beamformer_if
//   Bundles the frame, configuration and result signals of the beamformer.
//   Handshake: there is no back-pressure. sample_valid is a one-cycle frame
//   strobe; a strobe that arrives while busy is dropped and flagged through
//   overrun. out_valid is a one-cycle result strobe; out_data holds its value
//   until the next out_valid.
//   master: frame source / host side.  slave: the beamformer core.
//   dbg_state exposes the core FSM state.
interface delay_sum_beamformer_if #(
    parameter int NUM_CH   = beamformer_pkg::NUM_CH_DEF,
    parameter int SAMPLE_W = beamformer_pkg::SAMPLE_W_DEF,
    parameter int DEPTH    = beamformer_pkg::DEPTH_DEF
);
    localparam int OUT_W = beamformer_pkg::calc_out_w(SAMPLE_W, NUM_CH);

    logic                       sample_valid;
    logic [NUM_CH*SAMPLE_W-1:0] sample_in;
    logic                       cfg_we;
    logic [$clog2(NUM_CH)-1:0]  cfg_ch;
    logic [$clog2(DEPTH)-1:0]   cfg_delay;
    logic                       cfg_commit;
    logic                       avg_mode;
    logic                       clr_overrun;
    logic                       out_valid;
    logic [OUT_W-1:0]           out_data;
    logic                       busy;
    logic                       overrun;
    beamformer_pkg::state_t     dbg_state;

    modport master (
        output sample_valid, sample_in, cfg_we, cfg_ch, cfg_delay, cfg_commit,
               avg_mode, clr_overrun,
        input  out_valid, out_data, busy, overrun, dbg_state
    );

    modport slave (
        input  sample_valid, sample_in, cfg_we, cfg_ch, cfg_delay, cfg_commit,
               avg_mode, clr_overrun,
        output out_valid, out_data, busy, overrun, dbg_state
    );

endinterface

// File: rtl/delay_sum_beamformer_ring.sv
// sample_ring
//   Circular history buffer for one channel.
//   Ports: clk, rst_n (async clear of every entry), we/wr_ptr/din (write
//   port), rd_idx -> dout (asynchronous read port).
module sample_ring #(
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_ptr,
    input  logic [SAMPLE_W-1:0]      din,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [SAMPLE_W-1:0]      dout
);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [SAMPLE_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wr_ptr] = din;
        end
    end

    // Cleared entries double as the "not yet written" value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dout = mem_q[rd_idx];

endmodule

// File: rtl/delay_sum_beamformer.sv
// delay_sum_beamformer
//   Stores each accepted frame of NUM_CH signed samples in per-channel ring
//   buffers, then sums one delayed sample per channel (one channel per
//   cycle) into out_data. Delays are double-buffered: cfg_we fills shadow
//   registers, cfg_commit copies them to the active set at a frame boundary.
//   Ports: clk, rst_n (async, active-low), bus (slave side of
//   delay_sum_beamformer_if).
module delay_sum_beamformer
    import beamformer_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    delay_sum_beamformer_if.slave  bus
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OUT_W = calc_out_w(SAMPLE_W, NUM_CH);

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          ch_idx_q, ch_idx_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         shadow_q [NUM_CH];
    logic [PTR_W-1:0]         shadow_d [NUM_CH];
    logic [PTR_W-1:0]         active_q [NUM_CH];
    logic [PTR_W-1:0]         active_d [NUM_CH];
    logic                     pending_q, pending_d;
    logic                     avg_q, avg_d;
    logic signed [OUT_W-1:0]  acc_q, acc_d;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     overrun_q, overrun_d;

    logic                     accept;
    logic                     drop;
    logic                     last_ch;
    logic                     commit_now;
    logic [PTR_W-1:0]         rd_idx    [NUM_CH];
    logic [SAMPLE_W-1:0]      ring_dout [NUM_CH];
    logic [SAMPLE_W-1:0]      cur_sample;
    logic signed [OUT_W-1:0]  cur_ext;
    logic signed [OUT_W-1:0]  acc_sum;

    assign accept  = bus.sample_valid && (state_q == IDLE);
    assign drop    = bus.sample_valid && (state_q == ACCUM);
    assign last_ch = (ch_idx_q == CH_W'(NUM_CH - 1));

    // wr_ptr has already advanced past the newest frame during ACCUM, so
    // delay 0 lands on wr_ptr-1; PTR_W-bit arithmetic gives the mod-DEPTH wrap.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ring
        assign rd_idx[c] = wr_ptr_q - PTR_W'(1) - active_q[c];

        sample_ring #(
            .SAMPLE_W (SAMPLE_W),
            .DEPTH    (DEPTH)
        ) u_ring (
            .clk    (clk),
            .rst_n  (rst_n),
            .we     (accept),
            .wr_ptr (wr_ptr_q),
            .din    (bus.sample_in[c*SAMPLE_W +: SAMPLE_W]),
            .rd_idx (rd_idx[c]),
            .dout   (ring_dout[c])
        );
    end

    assign cur_sample = ring_dout[ch_idx_q];
    assign cur_ext    = {{CH_W{cur_sample[SAMPLE_W-1]}}, cur_sample};
    assign acc_sum    = acc_q + cur_ext;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.sample_valid) state_d = ACCUM;
            ACCUM:   if (last_ch)          state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // FSM outputs and datapath next values
    always_comb begin
        ch_idx_d    = ch_idx_q;
        wr_ptr_d    = wr_ptr_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        pending_d   = pending_q;
        avg_d       = avg_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (bus.cfg_we) begin
            shadow_d[bus.cfg_ch] = bus.cfg_delay;
        end

        // shadow_q is the pre-write value, so a same-cycle cfg_we is not
        // part of this commit. A deferred commit lands on the next accept.
        commit_now = accept ? (bus.cfg_commit || pending_q)
                            : ((state_q == IDLE) && bus.cfg_commit);
        if (commit_now) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (bus.cfg_commit && (state_q == ACCUM)) begin
            pending_d = 1'b1;
        end

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            acc_d    = '0;
            ch_idx_d = '0;
            avg_d    = bus.avg_mode;
        end else if (state_q == ACCUM) begin
            acc_d    = acc_sum;
            ch_idx_d = ch_idx_q + CH_W'(1);
            if (last_ch) begin
                out_data_d  = avg_q ? (acc_sum >>> CH_W) : acc_sum;
                out_valid_d = 1'b1;
            end
        end

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_idx_q    <= '0;
            wr_ptr_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            pending_q   <= 1'b0;
            avg_q       <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            ch_idx_q    <= ch_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            avg_q       <= avg_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q == ACCUM);
    assign bus.overrun   = overrun_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// tb_delay_sum_beamformer
//   Directed bench for delay_sum_beamformer with NUM_CH=4, SAMPLE_W=16,
//   DEPTH=16 (OUT_W=18). Results are checked through an expected queue
//   drained by a negedge monitor, plus cycle-exact checks of status outputs.
module tb_delay_sum_beamformer;
    import beamformer_pkg::*;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 16;
    localparam int DEPTH    = 16;
    localparam int OUT_W    = 18;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    delay_sum_beamformer_if #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH)
    ) bus ();

    delay_sum_beamformer #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int ov_cnt  = 0;
    logic [OUT_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [OUT_W-1:0] obs,
                         input logic [OUT_W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid) begin
            ov_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", bus.out_valid, 1'b0);
            end else begin
                check("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        bus.cfg_we       = 1'b0;
        bus.cfg_ch       = '0;
        bus.cfg_delay    = '0;
        bus.cfg_commit   = 1'b0;
        bus.avg_mode     = 1'b0;
        bus.clr_overrun  = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_exp(input int v);
        exp_q.push_back(OUT_W'(v));
    endtask

    // One-cycle strobe; returns one cycle after the accept edge (cycle T+1).
    task automatic drive_frame(input int s0, input int s1, input int s2,
                               input int s3, input logic avg);
        bus.sample_in    = {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
        bus.avg_mode     = avg;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    // Full frame; returns in cycle T+NUM_CH+1, where the result is visible.
    task automatic send_frame(input int s0, input int s1, input int s2,
                              input int s3, input logic avg);
        drive_frame(s0, s1, s2, s3, avg);
        repeat (NUM_CH) tick();
    endtask

    task automatic cfg_write(input int ch, input int dly);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = 2'(ch);
        bus.cfg_delay = 4'(dly);
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic cfg_commit_pulse();
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int ov_before;
        idle_inputs();
        #2;

        // Reset with a frame strobe held active
        bus.sample_valid = 1'b1;
        bus.sample_in    = {4{16'd7}};
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data",  bus.out_data,  '0);
        check("rst_busy",      bus.busy,      1'b0);
        check("rst_overrun",   bus.overrun,   1'b0);
        check("rst_state",     bus.dbg_state, IDLE);
        bus.sample_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // First frame, cycle-exact latency
        push_exp(10);
        drive_frame(1, 2, 3, 4, 1'b0);
        check("busy_t1",  bus.busy,      1'b1);
        check("state_t1", bus.dbg_state, ACCUM);
        repeat (3) tick();
        check("busy_t4",      bus.busy,      1'b1);
        check("out_valid_t4", bus.out_valid, 1'b0);
        tick();
        check("out_valid_t5", bus.out_valid, 1'b1);
        check("out_data_t5",  bus.out_data,  18'd10);
        check("busy_t5",      bus.busy,      1'b0);

        // Channel 2 delayed by 3 frames, impulse then zeros
        do_reset();
        cfg_write(2, 3);
        cfg_commit_pulse();
        push_exp(300); send_frame(100, 100, 100, 100, 1'b0);
        push_exp(0);   send_frame(0, 0, 0, 0, 1'b0);
        push_exp(0);   send_frame(0, 0, 0, 0, 1'b0);
        push_exp(100); send_frame(0, 0, 0, 0, 1'b0);
        push_exp(0);   send_frame(0, 0, 0, 0, 1'b0);

        // Average mode rounds toward -inf
        do_reset();
        push_exp(-6);  send_frame(-5, -5, -5, -6, 1'b1);
        push_exp(-21); send_frame(-5, -5, -5, -6, 1'b0);

        // Overrun: dropped frame leaves history and wr_ptr alone
        do_reset();
        push_exp(4);
        drive_frame(1, 1, 1, 1, 1'b0);
        tick();
        bus.sample_in    = {4{16'd50}};
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        check("overrun_set", bus.overrun, 1'b1);
        tick();
        tick();
        for (int c = 0; c < NUM_CH; c++) cfg_write(c, 1);
        cfg_commit_pulse();
        check("overrun_sticky", bus.overrun, 1'b1);
        bus.clr_overrun = 1'b1;
        tick();
        bus.clr_overrun = 1'b0;
        check("overrun_clr", bus.overrun, 1'b0);
        push_exp(4);
        drive_frame(2, 2, 2, 2, 1'b0);
        tick();
        bus.sample_in    = {4{16'd60}};
        bus.sample_valid = 1'b1;
        bus.clr_overrun  = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        bus.clr_overrun  = 1'b0;
        check("overrun_set_wins", bus.overrun, 1'b1);
        tick();
        tick();
        push_exp(8);
        send_frame(3, 3, 3, 3, 1'b0);

        // Commit while busy is deferred to the next frame
        do_reset();
        cfg_write(3, 1);
        push_exp(10);
        drive_frame(1, 2, 3, 4, 1'b0);
        tick();
        cfg_commit_pulse();
        tick();
        tick();
        push_exp(64);
        send_frame(10, 20, 30, 40, 1'b0);
        // Same-cycle write and commit: commit takes the old shadow value
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = 2'd1;
        bus.cfg_delay  = 4'd2;
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_we     = 1'b0;
        bus.cfg_commit = 1'b0;
        push_exp(58);
        send_frame(5, 6, 7, 8, 1'b0);
        cfg_commit_pulse();
        push_exp(30);
        send_frame(1, 1, 1, 1, 1'b0);

        // Pointer wrap: channel 0 at delay 15, others at 0
        do_reset();
        cfg_write(0, 15);
        cfg_commit_pulse();
        for (int k = 0; k < 40; k++) begin
            push_exp(12 * k + 9 + ((k >= 15) ? (4 * (k - 15) + 1) : 0));
            send_frame(4 * k + 1, 4 * k + 2, 4 * k + 3, 4 * k + 4, 1'b0);
        end

        // Reset asserted mid-accumulation
        tick();
        ov_before = ov_cnt;
        drive_frame(9, 9, 9, 9, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy",      bus.busy,      1'b0);
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_state",     bus.dbg_state, IDLE);
        tick();
        rst_n = 1'b1;
        repeat (NUM_CH + 3) tick();
        check("midrst_no_out_valid", OUT_W'(ov_cnt - ov_before), '0);
        check("midrst_overrun",      bus.overrun, 1'b0);
        push_exp(4);
        send_frame(1, 1, 1, 1, 1'b0);
        tick();
        check("exp_q_drained", OUT_W'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
